// File: rtl/flag_ctrl.sv
// Z/V/N flag-register controller: tracks one outstanding flag-writing ALU op,
// commits masked ALU flags, and evaluates branch conditions on committed flags.
module flag_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       issue_valid,
  input  logic [3:0] issue_opcode,
  output logic       issue_ready,
  input  logic       alu_valid,
  input  logic [2:0] alu_flags,
  input  logic       br_req,
  input  logic [2:0] br_cond,
  output logic       br_ready,
  output logic       br_valid,
  output logic       br_taken,
  output logic [2:0] flag_out,
  output logic [7:0] stall_cnt
);

  // Handshakes: an issue is accepted on a rising edge when issue_valid and
  // issue_ready are both high; a branch is accepted when br_req and br_ready
  // are both high. Neither ready depends combinationally on its own valid.

  typedef enum logic {IDLE = 1'b0, PEND = 1'b1} state_e;

  state_e     state_q, state_d;
  logic [2:0] pend_mask_q, pend_mask_d;
  logic [2:0] flag_q, flag_d;
  logic       br_valid_q, br_valid_d;
  logic       br_taken_q, br_taken_d;
  logic [7:0] stall_cnt_q, stall_cnt_d;

  logic [2:0] issue_mask;
  logic [2:0] dep_mask;
  logic       cond_true;
  logic       flag_z, flag_v, flag_n;

  assign flag_z = flag_q[2];
  assign flag_v = flag_q[1];
  assign flag_n = flag_q[0];

  always_comb begin
    issue_mask = 3'b000;
    case (issue_opcode)
      4'b0000, 4'b0001:          issue_mask = 3'b111;
      4'b0010, 4'b0100,
      4'b0101, 4'b0110:          issue_mask = 3'b100;
      default:                   issue_mask = 3'b000;
    endcase
  end

  always_comb begin
    dep_mask  = 3'b000;
    cond_true = 1'b0;
    case (br_cond)
      3'b000: begin dep_mask = 3'b100; cond_true = !flag_z;            end
      3'b001: begin dep_mask = 3'b100; cond_true = flag_z;             end
      3'b010: begin dep_mask = 3'b101; cond_true = !flag_z && !flag_n; end
      3'b011: begin dep_mask = 3'b001; cond_true = flag_n;             end
      3'b100: begin dep_mask = 3'b101; cond_true = flag_z || !flag_n;  end
      3'b101: begin dep_mask = 3'b101; cond_true = flag_n || flag_z;   end
      3'b110: begin dep_mask = 3'b010; cond_true = flag_v;             end
      default: begin dep_mask = 3'b000; cond_true = 1'b1;              end
    endcase
  end

  assign br_ready = ((dep_mask & pend_mask_q) == 3'b000);

  always_comb begin
    state_d     = state_q;
    pend_mask_d = pend_mask_q;
    flag_d      = flag_q;
    issue_ready = 1'b0;
    case (state_q)
      IDLE: begin
        issue_ready = 1'b1;
        if (issue_valid && (issue_mask != 3'b000)) begin
          pend_mask_d = issue_mask;
          state_d     = PEND;
        end
      end
      PEND: begin
        if (alu_valid) begin
          flag_d      = (flag_q & ~pend_mask_q) | (alu_flags & pend_mask_q);
          pend_mask_d = 3'b000;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        pend_mask_d = 3'b000;
      end
    endcase
  end

  // Branch result uses pre-edge flags, so a same-cycle issue never affects it.
  always_comb begin
    br_valid_d  = br_req && br_ready;
    br_taken_d  = br_taken_q;
    stall_cnt_d = stall_cnt_q;
    if (br_req && br_ready) br_taken_d = cond_true;
    if (br_req && !br_ready && (stall_cnt_q != 8'hFF)) stall_cnt_d = stall_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      pend_mask_q <= 3'b000;
      flag_q      <= 3'b000;
      br_valid_q  <= 1'b0;
      br_taken_q  <= 1'b0;
      stall_cnt_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      pend_mask_q <= pend_mask_d;
      flag_q      <= flag_d;
      br_valid_q  <= br_valid_d;
      br_taken_q  <= br_taken_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign flag_out  = flag_q;
  assign br_valid  = br_valid_q;
  assign br_taken  = br_taken_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_flag_ctrl.sv
// Directed self-checking bench for flag_ctrl: commit masking, branch stalls,
// same-cycle issue/branch ordering, stall saturation and mid-op reset.
module tb_flag_ctrl;

  logic       clk;
  logic       rst;
  logic       issue_valid;
  logic [3:0] issue_opcode;
  logic       issue_ready;
  logic       alu_valid;
  logic [2:0] alu_flags;
  logic       br_req;
  logic [2:0] br_cond;
  logic       br_ready;
  logic       br_valid;
  logic       br_taken;
  logic [2:0] flag_out;
  logic [7:0] stall_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  flag_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .issue_valid  (issue_valid),
    .issue_opcode (issue_opcode),
    .issue_ready  (issue_ready),
    .alu_valid    (alu_valid),
    .alu_flags    (alu_flags),
    .br_req       (br_req),
    .br_cond      (br_cond),
    .br_ready     (br_ready),
    .br_valid     (br_valid),
    .br_taken     (br_taken),
    .flag_out     (flag_out),
    .stall_cnt    (stall_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    issue_valid  = 1'b0;
    issue_opcode = 4'b0000;
    alu_valid    = 1'b0;
    alu_flags    = 3'b000;
    br_req       = 1'b0;
    br_cond      = 3'b000;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle_inputs();
    #2;
    n_checks++; if (flag_out !== 3'b000) begin n_fail++; $display("FAIL reset_flags got=%b exp=000", flag_out); end
    n_checks++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL reset_issue_ready got=%b exp=1", issue_ready); end
    n_checks++; if (br_ready !== 1'b1) begin n_fail++; $display("FAIL reset_br_ready got=%b exp=1", br_ready); end
    n_checks++; if (br_valid !== 1'b0) begin n_fail++; $display("FAIL reset_br_valid got=%b exp=0", br_valid); end
    n_checks++; if (br_taken !== 1'b0) begin n_fail++; $display("FAIL reset_br_taken got=%b exp=0", br_taken); end
    n_checks++; if (stall_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_stall got=%0d exp=0", stall_cnt); end
    #10;
    rst = 1'b1;
    tick();
  endtask

  task automatic test_add_commit();
    issue_valid = 1'b1; issue_opcode = 4'b0000;
    tick();
    issue_valid = 1'b0;
    #1;
    n_checks++; if (issue_ready !== 1'b0) begin n_fail++; $display("FAIL add_pend_ready got=%b exp=0", issue_ready); end
    alu_valid = 1'b1; alu_flags = 3'b101;
    tick();
    alu_valid = 1'b0;
    n_checks++; if (flag_out !== 3'b101) begin n_fail++; $display("FAIL add_commit got=%b exp=101", flag_out); end
    n_checks++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL add_ready_back got=%b exp=1", issue_ready); end
  endtask

  task automatic test_xor_partial();
    issue_valid = 1'b1; issue_opcode = 4'b0000;
    tick();
    issue_valid = 1'b0; alu_valid = 1'b1; alu_flags = 3'b111;
    tick();
    alu_valid = 1'b0;
    n_checks++; if (flag_out !== 3'b111) begin n_fail++; $display("FAIL xor_setup got=%b exp=111", flag_out); end
    issue_valid = 1'b1; issue_opcode = 4'b0010;
    tick();
    issue_valid = 1'b0; alu_valid = 1'b1; alu_flags = 3'b010;
    tick();
    alu_valid = 1'b0;
    n_checks++; if (flag_out !== 3'b011) begin n_fail++; $display("FAIL xor_partial got=%b exp=011", flag_out); end
  endtask

  // flags = 011 on entry
  task automatic test_ovfl_stall();
    issue_valid = 1'b1; issue_opcode = 4'b0001;
    tick();
    issue_valid = 1'b0;
    br_req = 1'b1; br_cond = 3'b110;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) begin alu_valid = 1'b1; alu_flags = 3'b010; end
      #1;
      n_checks++; if (br_ready !== 1'b0) begin n_fail++; $display("FAIL ovfl_stall_%0d got=%b exp=0", i, br_ready); end
      tick();
    end
    alu_valid = 1'b0;
    #1;
    n_checks++; if (flag_out !== 3'b010) begin n_fail++; $display("FAIL ovfl_commit got=%b exp=010", flag_out); end
    n_checks++; if (stall_cnt !== 8'd3) begin n_fail++; $display("FAIL ovfl_stall_cnt got=%0d exp=3", stall_cnt); end
    n_checks++; if (br_ready !== 1'b1) begin n_fail++; $display("FAIL ovfl_ready got=%b exp=1", br_ready); end
    n_checks++; if (br_valid !== 1'b0) begin n_fail++; $display("FAIL ovfl_no_valid got=%b exp=0", br_valid); end
    tick();
    br_req = 1'b0;
    n_checks++; if (br_valid !== 1'b1) begin n_fail++; $display("FAIL ovfl_br_valid got=%b exp=1", br_valid); end
    n_checks++; if (br_taken !== 1'b1) begin n_fail++; $display("FAIL ovfl_br_taken got=%b exp=1", br_taken); end
    tick();
    n_checks++; if (br_valid !== 1'b0) begin n_fail++; $display("FAIL ovfl_pulse got=%b exp=0", br_valid); end
    n_checks++; if (br_taken !== 1'b1) begin n_fail++; $display("FAIL ovfl_taken_hold got=%b exp=1", br_taken); end
    n_checks++; if (stall_cnt !== 8'd3) begin n_fail++; $display("FAIL ovfl_stall_keep got=%0d exp=3", stall_cnt); end
  endtask

  // flags = 010 on entry, stall_cnt = 3
  task automatic test_back_to_back();
    issue_valid = 1'b1; issue_opcode = 4'b0010;
    tick();
    issue_valid = 1'b0;
    br_req = 1'b1; br_cond = 3'b110;
    #1;
    n_checks++; if (br_ready !== 1'b1) begin n_fail++; $display("FAIL indep_ready got=%b exp=1", br_ready); end
    tick();
    n_checks++; if (br_valid !== 1'b1 || br_taken !== 1'b1) begin n_fail++; $display("FAIL indep_ovfl got=%b%b exp=11", br_valid, br_taken); end
    br_cond = 3'b111;
    #1;
    n_checks++; if (br_ready !== 1'b1) begin n_fail++; $display("FAIL uncond_ready got=%b exp=1", br_ready); end
    tick();
    n_checks++; if (br_valid !== 1'b1 || br_taken !== 1'b1) begin n_fail++; $display("FAIL uncond_result got=%b%b exp=11", br_valid, br_taken); end
    br_cond = 3'b001;
    #1;
    n_checks++; if (br_ready !== 1'b0) begin n_fail++; $display("FAIL eq_dep_ready got=%b exp=0", br_ready); end
    tick();
    n_checks++; if (br_valid !== 1'b0) begin n_fail++; $display("FAIL eq_dep_valid got=%b exp=0", br_valid); end
    n_checks++; if (stall_cnt !== 8'd4) begin n_fail++; $display("FAIL eq_dep_stall got=%0d exp=4", stall_cnt); end
    br_req = 1'b0; alu_valid = 1'b1; alu_flags = 3'b111;
    tick();
    alu_valid = 1'b0;
    n_checks++; if (flag_out !== 3'b110) begin n_fail++; $display("FAIL xor_z_only got=%b exp=110", flag_out); end
    br_req = 1'b1; br_cond = 3'b000;
    tick();
    br_req = 1'b0;
    n_checks++; if (br_valid !== 1'b1 || br_taken !== 1'b0) begin n_fail++; $display("FAIL ne_result got=%b%b exp=10", br_valid, br_taken); end
    br_req = 1'b1; br_cond = 3'b010;
    tick();
    br_cond = 3'b100;
    n_checks++; if (br_valid !== 1'b1 || br_taken !== 1'b0) begin n_fail++; $display("FAIL gt_result got=%b%b exp=10", br_valid, br_taken); end
    tick();
    br_cond = 3'b011;
    n_checks++; if (br_valid !== 1'b1 || br_taken !== 1'b1) begin n_fail++; $display("FAIL gte_result got=%b%b exp=11", br_valid, br_taken); end
    tick();
    br_req = 1'b0;
    n_checks++; if (br_valid !== 1'b1 || br_taken !== 1'b0) begin n_fail++; $display("FAIL lt_result got=%b%b exp=10", br_valid, br_taken); end
  endtask

  // flags = 110 on entry
  task automatic test_zero_mask();
    issue_valid = 1'b1; issue_opcode = 4'b1000;
    tick();
    issue_opcode = 4'b0011;
    n_checks++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL lw_ready got=%b exp=1", issue_ready); end
    tick();
    issue_valid = 1'b0; alu_valid = 1'b1; alu_flags = 3'b001;
    n_checks++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL op3_ready got=%b exp=1", issue_ready); end
    tick();
    alu_valid = 1'b0;
    n_checks++; if (flag_out !== 3'b110) begin n_fail++; $display("FAIL stray_alu got=%b exp=110", flag_out); end
  endtask

  // flags = 110 on entry: branch sees Z=1 even though ADD issues the same cycle
  task automatic test_same_cycle();
    issue_valid = 1'b1; issue_opcode = 4'b0000;
    br_req = 1'b1; br_cond = 3'b001;
    #1;
    n_checks++; if (br_ready !== 1'b1) begin n_fail++; $display("FAIL same_br_ready got=%b exp=1", br_ready); end
    tick();
    issue_valid = 1'b0; br_req = 1'b0;
    n_checks++; if (br_valid !== 1'b1 || br_taken !== 1'b1) begin n_fail++; $display("FAIL same_br_result got=%b%b exp=11", br_valid, br_taken); end
    n_checks++; if (issue_ready !== 1'b0) begin n_fail++; $display("FAIL same_issue_pend got=%b exp=0", issue_ready); end
    alu_valid = 1'b1; alu_flags = 3'b000;
    tick();
    alu_valid = 1'b0;
    n_checks++; if (flag_out !== 3'b000) begin n_fail++; $display("FAIL same_commit got=%b exp=000", flag_out); end
  endtask

  // stall_cnt = 4 on entry
  task automatic test_stall_saturate();
    issue_valid = 1'b1; issue_opcode = 4'b0101;
    tick();
    issue_valid = 1'b0;
    br_req = 1'b1; br_cond = 3'b000;
    for (int i = 0; i < 250; i++) tick();
    n_checks++; if (stall_cnt !== 8'd254) begin n_fail++; $display("FAIL stall_254 got=%0d exp=254", stall_cnt); end
    tick();
    n_checks++; if (stall_cnt !== 8'd255) begin n_fail++; $display("FAIL stall_255 got=%0d exp=255", stall_cnt); end
    for (int i = 0; i < 5; i++) tick();
    n_checks++; if (stall_cnt !== 8'd255) begin n_fail++; $display("FAIL stall_sat got=%0d exp=255", stall_cnt); end
    br_req = 1'b0; alu_valid = 1'b1; alu_flags = 3'b111;
    tick();
    alu_valid = 1'b0;
    n_checks++; if (flag_out !== 3'b100) begin n_fail++; $display("FAIL sra_commit got=%b exp=100", flag_out); end
  endtask

  task automatic test_reset_mid_pend();
    issue_valid = 1'b1; issue_opcode = 4'b0000;
    tick();
    issue_valid = 1'b0; br_req = 1'b1; br_cond = 3'b111;
    tick();
    br_req = 1'b0;
    n_checks++; if (br_valid !== 1'b1) begin n_fail++; $display("FAIL pre_rst_valid got=%b exp=1", br_valid); end
    #1;
    rst = 1'b0;
    #1;
    n_checks++; if (flag_out !== 3'b000) begin n_fail++; $display("FAIL rst_mid_flags got=%b exp=000", flag_out); end
    n_checks++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_ready got=%b exp=1", issue_ready); end
    n_checks++; if (br_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_valid got=%b exp=0", br_valid); end
    n_checks++; if (stall_cnt !== 8'd0) begin n_fail++; $display("FAIL rst_mid_stall got=%0d exp=0", stall_cnt); end
    #1;
    rst = 1'b1;
    alu_valid = 1'b1; alu_flags = 3'b111;
    tick();
    alu_valid = 1'b0;
    n_checks++; if (flag_out !== 3'b000) begin n_fail++; $display("FAIL rst_late_alu got=%b exp=000", flag_out); end
    n_checks++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL rst_late_ready got=%b exp=1", issue_ready); end
  endtask

  initial begin
    test_reset();
    test_add_commit();
    test_xor_partial();
    test_ovfl_stall();
    test_back_to_back();
    test_zero_mask();
    test_same_cycle();
    test_stall_saturate();
    test_reset_mid_pend();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
